// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX stage: ALU control codes, ALUOp encodings, funct constants,
// the ID/EX register layout and the operand forwarding helper.
package id_ex_stage_pkg;

  localparam int DW = 32;
  localparam int RW = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOP = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [1:0]    alu_op;
    logic [5:0]    funct;
    logic          alu_src;
    logic          reg_dst;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
  } idex_t;

  // MEM result is younger than WB, so it wins; $0 is hardwired and never forwarded.
  function automatic logic [DW-1:0] fwd(
    input logic [RW-1:0] idx,
    input logic [DW-1:0] reg_val,
    input logic          mem_we,
    input logic [RW-1:0] mem_idx,
    input logic [DW-1:0] mem_val,
    input logic          wb_we,
    input logic [RW-1:0] wb_idx,
    input logic [DW-1:0] wb_val
  );
    logic [DW-1:0] res;
    res = reg_val;
    if (idx != '0) begin
      if (mem_we && mem_idx == idx)     res = mem_val;
      else if (wb_we && wb_idx == idx)  res = wb_val;
    end
    return res;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between the decode/writeback side and the ID/EX stage.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic          flush;
  logic          hold;
  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic          id_uses_rt;
  logic [1:0]    id_alu_op;
  logic [5:0]    id_funct;
  logic          id_alu_src;
  logic          id_reg_dst;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          id_mem_to_reg;
  logic          mem_reg_write;
  logic          wb_reg_write;
  logic [RW-1:0] mem_rd;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] mem_result;
  logic [DW-1:0] wb_result;
  logic          load_use_stall;
  logic          ex_valid;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_ctrl;
  logic [DW-1:0] ex_store_data;
  logic [RW-1:0] ex_dest;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_mem_to_reg;

  modport master (
    output flush, hold, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_uses_rt, id_alu_op, id_funct, id_alu_src, id_reg_dst, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg,
           mem_reg_write, wb_reg_write, mem_rd, wb_rd, mem_result, wb_result,
    input  load_use_stall, ex_valid, alu_a, alu_b, alu_ctrl, ex_store_data, ex_dest,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
  );

  modport slave (
    input  flush, hold, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_uses_rt, id_alu_op, id_funct, id_alu_src, id_reg_dst, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg,
           mem_reg_write, wb_reg_write, mem_rd, wb_rd, mem_result, wb_result,
    output load_use_stall, ex_valid, alu_a, alu_b, alu_ctrl, ex_store_data, ex_dest,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
  );

endinterface

// File: rtl/id_ex_stage_alu_ctrl_dec.sv
// ALUOp/funct to ALUControl decoder, purely combinational.
module alu_ctrl_dec
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_NOP;
    case (alu_op)
      ALUOP_ADD:   alu_ctrl = ALU_ADD;
      ALUOP_SUB:   alu_ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_ctrl = ALU_ADD;
          FUNCT_SUB: alu_ctrl = ALU_SUB;
          FUNCT_AND: alu_ctrl = ALU_AND;
          FUNCT_OR:  alu_ctrl = ALU_OR;
          FUNCT_SLT: alu_ctrl = ALU_SLT;
          default:   alu_ctrl = ALU_NOP;
        endcase
      end
      default:     alu_ctrl = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage forwarding, immediate select and load-use detection.
// One cycle ID->EX; hold freezes the register, flush/stall insert a bubble.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);

  idex_t         id_in;
  idex_t         ex;
  logic [RW-1:0] dest;
  logic          stall;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  always_comb begin
    id_in            = '0;
    id_in.valid      = bus.id_valid;
    id_in.rs         = bus.id_rs;
    id_in.rt         = bus.id_rt;
    id_in.rd         = bus.id_rd;
    id_in.rs_data    = bus.id_rs_data;
    id_in.rt_data    = bus.id_rt_data;
    id_in.imm        = bus.id_imm;
    id_in.alu_op     = bus.id_alu_op;
    id_in.funct      = bus.id_funct;
    id_in.alu_src    = bus.id_alu_src;
    id_in.reg_dst    = bus.id_reg_dst;
    id_in.reg_write  = bus.id_reg_write;
    id_in.mem_read   = bus.id_mem_read;
    id_in.mem_write  = bus.id_mem_write;
    id_in.mem_to_reg = bus.id_mem_to_reg;
  end

  assign dest = ex.reg_dst ? ex.rd : ex.rt;

  // Hold means EX is not advancing, so the load cannot collide with ID yet.
  assign stall = !bus.hold && ex.valid && ex.mem_read && (dest != '0) && bus.id_valid &&
                 ((dest == bus.id_rs) || (bus.id_uses_rt && (dest == bus.id_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ex <= '0;
    else if (bus.flush) ex <= '0;
    else if (bus.hold)  ex <= ex;
    else if (stall)     ex <= '0;
    else                ex <= id_in;
  end

  assign fwd_rs = fwd(ex.rs, ex.rs_data, bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                      bus.wb_reg_write, bus.wb_rd, bus.wb_result);
  assign fwd_rt = fwd(ex.rt, ex.rt_data, bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                      bus.wb_reg_write, bus.wb_rd, bus.wb_result);

  // A bubble has alu_op 00, which decodes to ADD as required for an idle ALU.
  alu_ctrl_dec u_dec (
    .alu_op   (ex.alu_op),
    .funct    (ex.funct),
    .alu_ctrl (bus.alu_ctrl)
  );

  assign bus.load_use_stall = stall;
  assign bus.ex_valid       = ex.valid;
  assign bus.alu_a          = fwd_rs;
  assign bus.alu_b          = ex.alu_src ? ex.imm : fwd_rt;
  assign bus.ex_store_data  = fwd_rt;
  assign bus.ex_dest        = dest;
  assign bus.ex_reg_write   = ex.reg_write;
  assign bus.ex_mem_read    = ex.mem_read;
  assign bus.ex_mem_write   = ex.mem_write;
  assign bus.ex_mem_to_reg  = ex.mem_to_reg;

endmodule
